// File: rtl/opacc_drain.sv
// opacc_drain: accumulator-store row drain FIFO with tile credit; OPACC_DRAIN_BYPASS_EN adds zero-latency empty bypass
module opacc_drain #(
  parameter int ml = 4,
  parameter int vl = 4,
  parameter int XLEN = 64,
  parameter int nregs = 2,
  parameter int DEPTH = 8,
  localparam int RW = ml > 1 ? $clog2(ml) : 1,
  localparam int TW = nregs > 1 ? $clog2(nregs) : 1,
  localparam int DW = vl * XLEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          co_valid,
  input  logic [DW-1:0] co,
  input  logic [TW-1:0] cst_addr,
  output logic          tile_credit,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_row,
  output logic [TW-1:0] wb_reg,
  output logic          wb_last,
  output logic          busy,
  output logic          overflow
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TW + RW + DW;
  if (DEPTH < ml) begin : g_depth_check
    $error("opacc_drain: DEPTH must be >= ml");
  end
  typedef enum logic {IDLE, CAPT} state_t;
  state_t state, state_d;
  logic [RW-1:0] row, row_d;
  logic [TW-1:0] tag, tag_d, cur_tag;
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] count, count_d;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] in_e, out_e;
  logic empty, full, byp, pop, push;
  assign cur_tag = state == IDLE ? cst_addr : tag;
  assign in_e = {cur_tag, row, co};
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
`ifdef OPACC_DRAIN_BYPASS_EN
  assign byp = empty && co_valid;
  assign out_e = byp ? in_e : empty ? '0 : mem[rd];
`else
  assign byp = 1'b0;
  assign out_e = empty ? '0 : mem[rd];
`endif
  assign wb_valid = !empty || byp;
  assign {wb_reg, wb_row, wb_data} = out_e;
  assign wb_last = wb_valid && wb_row == RW'(ml - 1);
  assign busy = !empty || state == CAPT;
  assign pop = !empty && wb_ready;
  assign push = co_valid && !(byp && wb_ready) && (!full || pop);
  assign count_d = count + CW'(push) - CW'(pop);
  always_comb begin
    state_d = state;
    row_d = row;
    tag_d = tag;
    if (co_valid) begin
      state_d = row == RW'(ml - 1) ? IDLE : CAPT;
      row_d = row == RW'(ml - 1) ? '0 : row + RW'(1);
      tag_d = cur_tag;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row <= '0;
      tag <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
      overflow <= 1'b0;
      tile_credit <= 1'b1;
    end else begin
      state <= state_d;
      row <= row_d;
      tag <= tag_d;
      count <= count_d;
      if (push) wr <= wr == PW'(DEPTH - 1) ? '0 : wr + PW'(1);
      if (pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + PW'(1);
      if (co_valid && full && !pop) overflow <= 1'b1;
      tile_credit <= CW'(DEPTH) - count_d >= CW'(ml);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= in_e;
  end
endmodule

// File: tb/tb_opacc_drain.sv
// tb_opacc_drain: directed plus random stimulus against a queue-based row model
module tb_opacc_drain;
  localparam int ML = 4;
  localparam int VL = 4;
  localparam int XL = 64;
  localparam int NR = 2;
  localparam int DP = 8;
  localparam int W = VL * XL;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic co_valid = 1'b0;
  logic wb_ready = 1'b0;
  logic cst_addr = 1'b0;
  logic [W-1:0] co = '0;
  logic tile_credit, wb_valid, wb_last, busy, overflow, wb_reg;
  logic [W-1:0] wb_data;
  logic [1:0] wb_row;
  opacc_drain #(.ml(ML), .vl(VL), .XLEN(XL), .nregs(NR), .DEPTH(DP)) dut (
    .clk(clk),
    .reset(reset),
    .co_valid(co_valid),
    .co(co),
    .cst_addr(cst_addr),
    .tile_credit(tile_credit),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_data(wb_data),
    .wb_row(wb_row),
    .wb_reg(wb_reg),
    .wb_last(wb_last),
    .busy(busy),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] d;
    int row;
    int tag;
  } ent_t;
  ent_t q[$];
  int m_row, m_tag;
  bit m_ovf, m_cred;
  int passed = 0;
  int total = 0;
  task automatic chk(input string t, input logic [W-1:0] o, input logic [W-1:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", t, o, e);
  endtask
  task automatic model_clear();
    q.delete();
    m_row = 0;
    m_tag = 0;
    m_ovf = 1'b0;
    m_cred = 1'b1;
  endtask
  task automatic check_outs();
    bit nv;
    nv = q.size() != 0;
    chk("wb_valid", W'(wb_valid), W'(nv));
    chk("wb_data", wb_data, nv ? q[0].d : '0);
    chk("wb_row", W'(wb_row), nv ? W'(q[0].row) : '0);
    chk("wb_reg", W'(wb_reg), nv ? W'(q[0].tag) : '0);
    chk("wb_last", W'(wb_last), W'(nv && q[0].row == ML - 1));
    chk("busy", W'(busy), W'(nv || m_row != 0));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("tile_credit", W'(tile_credit), W'(m_cred));
  endtask
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit a, input bit r);
    bit pop;
    co_valid = v;
    co = d;
    cst_addr = a;
    wb_ready = r;
    #1 check_outs();
    pop = q.size() != 0 && r;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (v) begin
      if (m_row == 0) m_tag = int'(a);
      if (q.size() < DP) q.push_back('{d, m_row, m_tag});
      else m_ovf = 1'b1;
      m_row = (m_row + 1) % ML;
    end
    m_cred = (DP - q.size()) >= ML;
    @(negedge clk);
  endtask
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction
  initial begin
    model_clear();
    @(negedge clk);
    #1 check_outs();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'h10 + i), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h20 + i), i >= 4, 1'b0);
    cyc(1'b1, W'(32'h30), 1'b0, 1'b1);
    cyc(1'b1, W'(32'h31), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    #1 model_clear();
    check_outs();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, W'(32'h40), 1'b1, 1'b0);
    cyc(1'b1, W'(32'h41), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, W'(32'h42), 1'b0, 1'b1);
    cyc(1'b1, W'(32'h43), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, W'(32'h50), 1'b1, 1'b0);
    cyc(1'b1, W'(32'h51), 1'b1, 1'b0);
    cyc(1'b1, W'(32'h52), 1'b1, 1'b0);
    reset = 1'b0;
    #1 model_clear();
    chk("async_rst_wb_valid", W'(wb_valid), '0);
    chk("async_rst_busy", W'(busy), '0);
    check_outs();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(32'h60 + i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/opacc_drain.md
Name: opacc_drain

Overview:
- Downstream drain stage for the outer-product accumulator array.
- Captures result rows streamed out of the array's `co` port during an accumulator-store sequence, one `vl`-wide row per `co_valid` beat, `ml` rows per tile.
- Buffers rows in a row FIFO and presents them to vector writeback on a valid/ready port, tagged with row index, source accumulator register and last-row flag.
- Issues a tile-granular credit so store issue never overruns the buffer.

Parameters:
- ml, 4: rows per tile; rows per store sequence.
- vl, 4: elements per row.
- XLEN, 64: element width in bits.
- nregs, 2: accumulator registers in the array; sets tag width.
- DEPTH, 8: FIFO depth in rows; DEPTH >= ml required; DEPTH < ml is a static elaboration error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- co_valid  in  1  row beat valid from the array.
- co  in  vl*XLEN  result row; element j at bits [j*XLEN +: XLEN].
- cst_addr  in  $clog2(nregs)  accumulator register being stored; sampled on row 0 only.
- tile_credit  out  1  at least ml free entries; store issue may start a tile.
- wb_valid  out  1  writeback row valid.
- wb_ready  in  1  writeback accepts row.
- wb_data  out  vl*XLEN  row data.
- wb_row  out  $clog2(ml)  row index within tile.
- wb_reg  out  $clog2(nregs)  source accumulator register.
- wb_last  out  1  row index == ml-1.
- busy  out  1  FIFO non-empty or FSM in CAPT.
- overflow  out  1  sticky; a row was dropped on a full FIFO.

Behaviour:
- Reset (reset low, async): FIFO empty, pointers 0, FSM IDLE, row counter 0, overflow 0. Outputs: wb_valid 0, wb_data 0, wb_row 0, wb_reg 0, wb_last 0, busy 0, tile_credit 1.
- FSM IDLE:
  - co_valid latches cst_addr as tile tag and pushes row 0 tagged with it.
  - Go to CAPT with row counter 1.
  - If ml == 1, stay in IDLE.
- FSM CAPT:
  - Each co_valid beat pushes a row with the current counter and the latched tag, then increments the counter.
  - After the push of row ml-1, return to IDLE and clear the counter.
  - Gaps without co_valid are legal; the FSM holds its state and counter.
  - cst_addr is ignored in CAPT.
- Push/pop rules:
  - Push occurs when co_valid=1 and (count < DEPTH, or a pop occurs this cycle).
  - Pop occurs when wb_valid && wb_ready.
  - Simultaneous push and pop on a full FIFO: both occur, count unchanged, no overflow.
- Overflow:
  - A push attempt on a full FIFO with no pop: row dropped, overflow set (sticky until reset).
  - The row counter still advances on a dropped row, so tile framing stays aligned.
- Latency: a row pushed in cycle n is visible on wb_* in cycle n+1 at the earliest. All wb_* outputs come directly from FIFO storage or registers.
- Backpressure: wb_valid = FIFO non-empty. wb_data, wb_row, wb_reg and wb_last hold stable while wb_valid && !wb_ready.
- Pointers: wrap modulo DEPTH; count width $clog2(DEPTH+1). Full = count==DEPTH; empty = count==0.
- tile_credit: registered; = (DEPTH - count_next) >= ml. A tile started under credit can never overflow.
- Reset mid-tile: discards all buffered rows and the partial tile; FSM returns to IDLE.

Optional Feature:
- OPACC_DRAIN_BYPASS_EN defined:
  - When the FIFO is empty and co_valid=1, wb_* is driven combinationally from co / current tag / counter in the same cycle, giving zero-cycle latency.
  - If wb_ready=1 that cycle, the row is consumed and not pushed.
  - If wb_ready=0, the row is pushed normally.
- Undefined: minimum latency is 1 cycle; wb_* carries no combinational path from co.

Test Plan:
- Reset, then one tile (ml=4, cst_addr=1, rows 0x10..0x13 in element 0, wb_ready=1) -> wb rows appear cycles 1..4 later; wb_row 0,1,2,3; wb_reg=1; wb_last only on row 3; busy drops after the last pop.
- Two back-to-back tiles (reg 0 then reg 1), wb_ready=0 throughout, DEPTH=8 -> count reaches 8, no overflow; tile_credit drops to 0 after the 5th row pushed; release wb_ready -> 8 rows drain in order, tags 0×4 then 1×4.
- FIFO full, wb_ready=0, extra co_valid beat -> row dropped, overflow=1 and stays 1; subsequent pops return the original 8 rows unchanged.
- FIFO full, co_valid and wb_ready same cycle -> pop of oldest row plus push of new row, count stays 8, overflow 0.
- Mid-tile gap: rows 0,1, three idle cycles with cst_addr changed to 0, rows 2,3 -> all four rows tagged with the originally latched register; wb_row 0..3 contiguous.
- Assert reset low after row 2 of a tile -> wb_valid=0 and busy=0 immediately (async). The next tile starts at wb_row 0 with a fresh tag.
